// File: rtl/bcd_seg_display.sv
// Two-digit BCD display driver: load-strobed holding registers,
// time-multiplexed common-anode 7-segment output.
module bcd_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit LZ_BLANK    = 1'b1,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic       blank,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [PW-1:0] presc;
  logic          idx;
  logic [3:0]    hold1;
  logic [3:0]    hold0;
  logic [3:0]    dig;
  logic [6:0]    pat;
  logic [1:0]    sel;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  always_comb begin
    dig = idx ? hold1 : hold0;
    pat = 7'h40;
    unique case (dig)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    sel = idx ? 2'b10 : 2'b01;
    // Only a true zero in the tens place is suppressed, never a dash.
    if (blank || (LZ_BLANK && idx && (hold1 == 4'd0))) begin
      pat = 7'h00;
      sel = 2'b00;
    end
    seg_nxt = ACTIVE_LOW ? ~pat : pat;
    an_nxt  = ACTIVE_LOW ? ~sel : sel;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      hold1 <= 4'd0;
      hold0 <= 4'd0;
      presc <= '0;
      idx   <= 1'b0;
      seg   <= SEG_OFF;
      an    <= AN_OFF;
    end else begin
      if (load) begin
        hold1 <= BCD1;
        hold0 <= BCD0;
      end
      if (presc == PMAX) begin
        presc <= '0;
        idx   <= ~idx;
      end else begin
        presc <= presc + 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: directed plan plus
// random traffic against a schedule-based reference model.
module tb_bcd_seg_display;

  localparam int DIV = 4;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
  } out_t;

  localparam logic [6:0] PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       load = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] BCD1 = 4'd0;
  logic [3:0] BCD0 = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;

  out_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   t = 0;
  logic [3:0] m1 = 4'd0;
  logic [3:0] m0 = 4'd0;

  bcd_seg_display #(
    .REFRESH_DIV(DIV),
    .LZ_BLANK(1'b1),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .clr(clr),
    .load(load),
    .blank(blank),
    .BCD1(BCD1),
    .BCD0(BCD0),
    .seg(seg),
    .an(an)
  );

  always #5 clk = ~clk;

  // Model: t = edges since the last clear; digit k lit for
  // edges where (t / DIV) is even (ones) or odd (tens).
  task automatic step(input logic c, input logic l,
                      input logic b, input logic [3:0] d1,
                      input logic [3:0] d0);
    out_t       e;
    int         ph;
    logic [3:0] dig;
    @(negedge clk);
    clr = c;
    load = l;
    blank = b;
    BCD1 = d1;
    BCD0 = d0;
    e.an = 2'b11;
    e.seg = 7'h7F;
    if (!c && !b) begin
      ph = (t / DIV) % 2;
      dig = (ph == 1) ? m1 : m0;
      if (!(ph == 1 && m1 == 4'd0)) begin
        e.seg = ~PAT[dig];
        e.an = (ph == 1) ? 2'b01 : 2'b10;
      end
    end
    q.push_back(e);
    if (c) begin
      m1 = 4'd0;
      m0 = 4'd0;
      t = 0;
    end else begin
      if (l) begin
        m1 = d1;
        m0 = d0;
      end
      t++;
    end
  endtask

  task automatic idle(input int n, input logic [3:0] d1,
                      input logic [3:0] d0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, d1, d0);
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({an, seg} !== e) begin
          failures++;
          $display("FAIL out t=%0t an=%b seg=%h exp an=%b seg=%h",
                   $time, an, seg, e.an, e.seg);
        end
      end
    end
  end

  initial begin : driver
    logic c, l, b;
    logic [3:0] d1, d0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(10, 4'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd4, 4'd7);
    idle(17, 4'd4, 4'd7);
    step(1'b0, 1'b1, 1'b0, 4'd0, 4'd5);
    idle(12, 4'd9, 4'd9);
    step(1'b0, 1'b1, 1'b0, 4'd1, 4'hC);
    idle(10, 4'd3, 4'd3);
    step(1'b1, 1'b1, 1'b0, 4'd8, 4'd8);
    idle(10, 4'd8, 4'd8);
    step(1'b0, 1'b1, 1'b0, 4'd4, 4'd7);
    idle(6, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 4'd2, 4'd2);
    idle(12, 4'd2, 4'd2);
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 79) == 0);
      l = ($urandom_range(0, 5) == 0);
      b = ($urandom_range(0, 9) == 0);
      d1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(0, 9));
      d0 = 4'($urandom_range(0, 15));
      step(c, l, b, d1, d0);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_seg_display.md
Name: bcd_seg_display

Overview:
- Display-side consumer of the two-digit BCD count (tens/ones) produced by the reaction-time counter.
- Captures the BCD pair on a load strobe and holds it.
- Time-multiplexes the held pair onto a two-digit common-anode 7-segment display, with leading-zero blanking, invalid-code indication and a global blank.
- Sits between the counter and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit; legal values ≥ 2.
- LZ_BLANK, 1: when 1, a tens digit of 0 is blanked.
- ACTIVE_LOW, 1: when 1, both seg and an are driven active-low; when 0, active-high.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  synchronous, active-high reset; one clock; highest priority.
- load  input  1  when high at an edge, BCD1/BCD0 are captured into the holding registers.
- blank  input  1  when high, all anodes inactive and all segments off.
- BCD1  input  4  tens digit from the counter.
- BCD0  input  4  ones digit from the counter.
- seg  output  7  segment drive {g,f,e,d,c,b,a}; registered.
- an  output  2  anode enables; an[0] = ones, an[1] = tens; registered.

Behaviour:
- Reset (clr=1 at an edge): the following hold from that edge on.
  - hold1 = hold0 = 0, prescaler = 0, scan index = 0.
  - an = all inactive (2'b11 when ACTIVE_LOW).
  - seg = all off (7'h7F when ACTIVE_LOW).
  - clr overrides load and blank in the same cycle.
- Capture: load=1 and clr=0 at edge N writes BCD1/BCD0 into hold1/hold0 at N.
  - Outputs reflect the new value at edge N+1 (1-cycle latency).
  - Input changes while load=0 have no effect.
- Prescaler: counts 0 to REFRESH_DIV-1.
  - At an edge where prescaler = REFRESH_DIV-1, it wraps to 0 and the scan index toggles.
  - The prescaler runs regardless of load and blank.
- Outputs are registered from the current state every cycle:
  - idx=0: ones digit selected (an[0] active), seg = decode(hold0).
  - idx=1: tens digit selected (an[1] active), seg = decode(hold1).
  - Each digit is therefore lit for exactly REFRESH_DIV consecutive cycles.
- Decode, active-high pattern before polarity:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 = 40 (dash, segment g only).
  - When ACTIVE_LOW=1, seg is the bitwise inverse of the pattern and an is the inverse of the one-hot select.
- Leading-zero blank: with LZ_BLANK=1, idx=1 and hold1=0, the tens anode is inactive and seg is all off.
  - An invalid tens code (10–15) is not blanked; the dash is shown.
- blank=1: the next edge drives all anodes inactive and seg all off.
  - Scan phase and held digits continue unaffected.
  - On release, the display resumes in whatever phase the scan reached.
- load and a prescaler wrap at the same edge: both take effect.
  - The next output shows the new digit for the new index.
- There is no stall or handshake; load may be asserted every cycle.

Test Plan (REFRESH_DIV=4, LZ_BLANK=1, ACTIVE_LOW=1):
- Reset: hold clr=1 for 3 cycles → an=2'b11, seg=7'h7F. First edge after release → an=2'b10, seg=7'h40 ("0"). 4 cycles later, tens phase → an=2'b11, seg=7'h7F (leading zero blanked).
- Load BCD1=4, BCD0=7:
  - Ones phase → an=2'b10, seg=7'h78.
  - Tens phase → an=2'b01, seg=7'h19.
  - Each phase lasts exactly 4 cycles; the phases alternate indefinitely.
- Load 0/5, then change the inputs to 9/9 with load=0:
  - Ones phase → seg=7'h12; tens phase blanked (an=2'b11).
  - Display stays 0/5 until the next load.
- Load BCD1=1, BCD0=4'hC:
  - Ones phase → seg=7'h3F (dash).
  - Tens phase → an=2'b01, seg=7'h79.
- Assert clr and load (with 8/8) in the same cycle → holds remain 0; output as in the reset case.
- With 4/7 displayed, raise blank for 6 cycles mid-phase:
  - While high → an=2'b11, seg=7'h7F.
  - After release → the digit shown matches the uninterrupted scan schedule (phase boundaries every 4 cycles since reset).
